// File: rtl/neander_mbyte_seq.sv
// neander_mbyte_seq: multi-byte arithmetic sequencer for a shared 8-bit ALU.
//
// Runs 1..4-byte ADD, SUB, SHL and SHR (logical) one byte per cycle. For each byte
// it drives the external combinational ALU and captures that ALU's result and
// carry at the end of the cycle.
//
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   start, op, nbytes         request pulse, opcode, operand length minus one
//   opa, opb                  32-bit little-endian operands (opb unused for shifts)
//   alu_a, alu_b, alu_op,     byte operands, opcode and carry-in driven to the ALU
//   alu_carry_in
//   alu_result, alu_carry_out ALU result byte and carry/borrow out
//   busy, done                sequence in progress, one-cycle completion pulse
//   result, carry, zero       final result, carry/borrow/shift-out bit, zero flag
module neander_mbyte_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [1:0]  nbytes,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_op,
    output logic        alu_carry_in,
    input  logic [7:0]  alu_result,
    input  logic        alu_carry_out,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        carry,
    output logic        zero
);

    typedef enum logic {StIdle, StRun} state_e;

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpShl = 2'b10;
    localparam logic [1:0] OpShr = 2'b11;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluShr = 4'b0111;
    localparam logic [3:0] AluAdc = 4'b1100;
    localparam logic [3:0] AluSbc = 4'b1101;

    state_e      r_state;
    state_e      w_state_d;
    logic [1:0]  r_op;
    logic [1:0]  r_nbytes;
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [1:0]  r_idx;
    logic        r_carry;
    logic [31:0] r_result;
    logic        r_done;
    logic        r_zero;

    logic [1:0]  w_pos;
    logic        w_last;
    logic [7:0]  w_a_byte;
    logic [7:0]  w_b_byte;
    logic [7:0]  w_store;
    logic [31:0] w_result_upd;

    // SHR walks from the most significant byte down, everything else walks up.
    assign w_pos    = (r_op == OpShr) ? (r_nbytes - r_idx) : r_idx;
    assign w_last   = (r_idx == r_nbytes);
    assign w_a_byte = r_opa[{w_pos, 3'b000} +: 8];
    assign w_b_byte = r_opb[{w_pos, 3'b000} +: 8];

    // For SHR the bit shifted out of the byte above becomes this byte's MSB.
    assign w_store  = (r_op == OpShr) ? (alu_result | {r_carry, 7'b0}) : alu_result;

    always_comb begin
        w_result_upd = r_result;
        w_result_upd[{w_pos, 3'b000} +: 8] = w_store;
    end

    // Next-state and ALU drive.
    always_comb begin
        w_state_d    = r_state;
        alu_a        = 8'h00;
        alu_b        = 8'h00;
        alu_op       = AluAdd;
        alu_carry_in = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                alu_a = w_a_byte;
                unique case (r_op)
                    OpAdd: begin
                        alu_b        = w_b_byte;
                        alu_op       = (r_idx == 2'd0) ? AluAdd : AluAdc;
                        alu_carry_in = (r_idx == 2'd0) ? 1'b0 : r_carry;
                    end
                    OpSub: begin
                        alu_b        = w_b_byte;
                        alu_op       = (r_idx == 2'd0) ? AluSub : AluSbc;
                        alu_carry_in = (r_idx == 2'd0) ? 1'b0 : r_carry;
                    end
                    OpShl: begin
                        // A + A shifts left by one with carry chaining.
                        alu_b        = w_a_byte;
                        alu_op       = (r_idx == 2'd0) ? AluAdd : AluAdc;
                        alu_carry_in = (r_idx == 2'd0) ? 1'b0 : r_carry;
                    end
                    OpShr: begin
                        alu_op = AluShr;
                    end
                    default: ;
                endcase
                if (w_last) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= 2'b00;
            r_nbytes <= 2'b00;
            r_opa    <= 32'h0;
            r_opb    <= 32'h0;
            r_idx    <= 2'd0;
            r_carry  <= 1'b0;
            r_result <= 32'h0;
            r_done   <= 1'b0;
            r_zero   <= 1'b0;
        end else if (r_state == StIdle) begin
            r_done <= 1'b0;
            if (start) begin
                r_op     <= op;
                r_nbytes <= nbytes;
                r_opa    <= opa;
                r_opb    <= opb;
                r_idx    <= 2'd0;
                r_carry  <= 1'b0;
                r_result <= 32'h0;
                r_zero   <= 1'b0;
            end
        end else begin
            r_result <= w_result_upd;
            r_carry  <= alu_carry_out;
            r_idx    <= r_idx + 2'd1;
            r_done   <= w_last;
            // Unused upper bytes stay cleared, so a whole-word compare covers 0..N-1 only.
            if (w_last) begin
                r_zero <= (w_result_upd == 32'h0);
            end
        end
    end

    assign busy   = (r_state == StRun);
    assign done   = r_done;
    assign result = r_result;
    assign carry  = r_carry;
    assign zero   = r_zero;

endmodule

// File: tb/tb_neander_mbyte_seq.sv
module tb_neander_mbyte_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [1:0]  nbytes;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_op;
    logic        alu_carry_in;
    logic [7:0]  alu_result;
    logic        alu_carry_out;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carry;
    logic        zero;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;

    logic [33:0] sb[$];      // {zero, carry, result}
    logic [3:0]  log_op[$];
    logic [7:0]  log_a[$];

    neander_mbyte_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .op            (op),
        .nbytes        (nbytes),
        .opa           (opa),
        .opb           (opb),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .alu_carry_in  (alu_carry_in),
        .alu_result    (alu_result),
        .alu_carry_out (alu_carry_out),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .carry         (carry),
        .zero          (zero)
    );

    always #5 clk = ~clk;

    // Behavioural 8-bit ALU.
    always_comb begin
        logic [8:0] t;
        t = 9'h0;
        case (alu_op)
            4'b0000: t = {1'b0, alu_a} + {1'b0, alu_b};
            4'b0001: t = {1'b0, alu_a} - {1'b0, alu_b};
            4'b1100: t = {1'b0, alu_a} + {1'b0, alu_b} + {8'h0, alu_carry_in};
            4'b1101: t = {1'b0, alu_a} - {1'b0, alu_b} - {8'h0, alu_carry_in};
            4'b0111: t = {alu_a[0], 1'b0, alu_a[7:1]};
            default: t = 9'h0;
        endcase
        alu_result    = t[7:0];
        alu_carry_out = t[8];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Whole-word reference model.
    function automatic logic [33:0] ref_model(input logic [1:0] o, input logic [1:0] nb,
                                              input logic [31:0] a, input logic [31:0] b);
        int          n;
        logic [31:0] m;
        logic [39:0] w;
        logic [31:0] r;
        logic        c;
        n = int'(nb) + 1;
        m = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
        case (o)
            2'b00: begin
                w = {8'h0, a & m} + {8'h0, b & m};
                c = w[8 * n];
                r = w[31:0] & m;
            end
            2'b01: begin
                c = (a & m) < (b & m);
                r = ((a & m) - (b & m)) & m;
            end
            2'b10: begin
                w = {8'h0, a & m} << 1;
                c = w[8 * n];
                r = w[31:0] & m;
            end
            default: begin
                r = (a & m) >> 1;
                c = a[0];
            end
        endcase
        return {(r == 32'h0), c, r};
    endfunction

    // Scoreboard: pop one expectation per done pulse.
    always @(posedge clk) begin
        #1;
        if (rst_n && done) begin
            logic [33:0] e;
            n_done++;
            if (sb.size() == 0) begin
                check("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_result", result, e[31:0]);
                check("sb_carry", {31'h0, carry}, {31'h0, e[32]});
                check("sb_zero", {31'h0, zero}, {31'h0, e[33]});
            end
        end
    end

    always @(negedge clk) begin
        if (busy) begin
            log_op.push_back(alu_op);
            log_a.push_back(alu_a);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [1:0] nb,
                          input logic [31:0] a, input logic [31:0] b);
        int cyc;
        @(negedge clk);
        log_op.delete();
        log_a.delete();
        op = o; nbytes = nb; opa = a; opb = b; start = 1'b1;
        sb.push_back(ref_model(o, nb, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_on", {31'h0, busy}, 32'd1);
        // Scramble operands mid-run; they must be ignored.
        op = 2'($urandom); nbytes = 2'($urandom); opa = $urandom; opb = $urandom;
        wait_done(cyc);
        check("latency", cyc, 32'(nb) + 32'd2);
        check("busy_at_done", {31'h0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] pack_ops();
        logic [31:0] p = 32'h0;
        foreach (log_op[i]) p = {p[27:0], log_op[i]};
        return p;
    endfunction

    function automatic logic [31:0] pack_a();
        logic [31:0] p = 32'h0;
        foreach (log_a[i]) p = {p[23:0], log_a[i]};
        return p;
    endfunction

    initial begin
        int cyc;
        int d0;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; nbytes = 2'b00; opa = 32'h0; opb = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_flags", {30'h0, carry, zero}, 32'd0);
        check("rst_alu", {19'h0, alu_a, alu_b, alu_op, alu_carry_in}, 32'h0);
        rst_n = 1'b1;

        // Four-byte add with carry ripple.
        run_op(2'b00, 2'd3, 32'h00FF_FFFF, 32'h0000_0001);
        check("add4_result", result, 32'h0100_0000);
        check("add4_flags", {30'h0, carry, zero}, 32'd0);
        check("add4_nops", log_op.size(), 32'd4);
        check("add4_ops", pack_ops(), 32'h0000_0CCC);

        // Two-byte subtract with borrow.
        run_op(2'b01, 2'd1, 32'h0000_0000, 32'h0000_0001);
        check("sub2_result", result, 32'h0000_FFFF);
        check("sub2_flags", {30'h0, carry, zero}, 32'd2);
        check("sub2_ops", pack_ops(), 32'h0000_001D);

        // Two-byte logical shift right, MSB first.
        run_op(2'b11, 2'd1, 32'h0000_0103, 32'hFFFF_FFFF);
        check("shr2_result", result, 32'h0000_0081);
        check("shr2_carry", {31'h0, carry}, 32'd1);
        check("shr2_order", pack_a(), 32'h0000_0103);
        check("shr2_ops", pack_ops(), 32'h0000_0077);

        // One-byte shift left producing zero.
        run_op(2'b10, 2'd0, 32'h0000_0080, 32'h0);
        check("shl1_result", result, 32'h0);
        check("shl1_flags", {30'h0, carry, zero}, 32'd3);

        // Flags and result hold in idle.
        repeat (3) @(negedge clk);
        check("hold_flags", {30'h0, carry, zero}, 32'd3);
        check("hold_done", {31'h0, done}, 32'd0);

        // Start pulsed during RUN is ignored.
        d0 = n_done;
        @(negedge clk);
        op = 2'b00; nbytes = 2'd3; opa = 32'h1234_5678; opb = 32'h0FED_CBA9; start = 1'b1;
        sb.push_back(ref_model(2'b00, 2'd3, 32'h1234_5678, 32'h0FED_CBA9));
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        op = 2'b01; nbytes = 2'd0; opa = 32'hFFFF_FFFF; opb = 32'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        repeat (6) @(negedge clk);
        check("ignore_start_dones", n_done - d0, 32'd1);
        check("ignore_start_result", result, 32'h2222_2221);

        // Reset mid-RUN.
        @(negedge clk);
        op = 2'b01; nbytes = 2'd3; opa = 32'hDEAD_BEEF; opb = 32'h1111_1111; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_busy", {31'h0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy_done", {30'h0, busy, done}, 32'd0);
        check("midrst_result", result, 32'h0);
        check("midrst_flags", {30'h0, carry, zero}, 32'd0);
        check("midrst_alu", {19'h0, alu_a, alu_b, alu_op, alu_carry_in}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b00, 2'd0, 32'h0000_0001, 32'h0000_0001);
        check("post_rst_result", result, 32'h0000_0002);

        // Back-to-back: start held across the done cycle.
        @(negedge clk);
        op = 2'b00; nbytes = 2'd1; opa = 32'h0000_80FF; opb = 32'h0000_8001; start = 1'b1;
        sb.push_back(ref_model(2'b00, 2'd1, 32'h0000_80FF, 32'h0000_8001));
        @(posedge clk);
        #1;
        wait_done(cyc);
        check("b2b_lat1", cyc, 32'd3);
        op = 2'b10; nbytes = 2'd2; opa = 32'h00C0_0001; opb = 32'h0;
        sb.push_back(ref_model(2'b10, 2'd2, 32'h00C0_0001, 32'h0));
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy2", {30'h0, busy, done}, 32'd2);
        wait_done(cyc);
        check("b2b_lat2", cyc, 32'd4);
        check("b2b_result2", result, 32'h0080_0002);
        check("b2b_carry2", {31'h0, carry}, 32'd1);

        // Random operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            run_op(2'($urandom), 2'($urandom), $urandom, $urandom);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/neander_mbyte_seq.md
NEANDER_MBYTE_SEQ -- requirements
Module: neander_mbyte_seq

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  request pulse; sampled only in IDLE.
REQ-004 op  input  2  00 ADD, 01 SUB, 10 SHL, 11 SHR (logical).
REQ-005 nbytes  input  2  operand length minus one (0 = 1 byte ... 3 = 4 bytes).
REQ-006 opa  input  32  operand A, little-endian bytes.
REQ-007 opb  input  32  operand B, little-endian bytes; ignored for SHL/SHR.
REQ-008 alu_a, alu_b  output  8 each  byte operands driven to the shared 8-bit ALU.
REQ-009 alu_op  output  4  ALU opcode (0000 ADD, 0001 SUB, 0111 SHR, 1100 ADC, 1101 SBC).
REQ-010 alu_carry_in  output  1  carry/borrow into the ALU.
REQ-011 alu_result  input  8  combinational ALU result byte.
REQ-012 alu_carry_out  input  1  combinational ALU carry/borrow out.
REQ-013 busy  output  1  high while a sequence is in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 result  output  32  multi-byte result; bytes above nbytes are zero.
REQ-016 carry  output  1  final carry/borrow/shifted-out bit.
REQ-017 zero  output  1  high when all N result bytes are zero.

Function
REQ-018 States: IDLE, RUN; RUN transitions to IDLE after processing byte N-1 of the sequence (N = nbytes+1).
REQ-019 In IDLE with start=1: latch op, nbytes, opa, opb; clear result, internal carry and byte index; enter RUN; busy=1 from the next cycle.
REQ-020 Latency: start sampled at edge k -> bytes processed at edges k+1..k+N -> done=1 and busy=0 during the cycle after edge k+N.
REQ-021 One byte per RUN cycle: the ALU is driven combinationally from the latched operands and the index; alu_result and alu_carry_out are captured at the end of the cycle.
REQ-022 ADD: byte 0 uses alu_op ADD with alu_carry_in=0; bytes 1..N-1 use ADC with alu_carry_in = previously captured carry; order LSB to MSB.
REQ-023 SUB: byte 0 uses SUB; bytes 1..N-1 use SBC with the chained borrow; final carry=1 means A<B over N bytes.
REQ-024 SHL: implemented as A+A, i.e. ADD/ADC with alu_a=alu_b=A byte; final carry = bit 8N-1 of A.
REQ-025 SHR: bytes processed MSB (index N-1) down to 0 with alu_op SHR and alu_carry_in=0; stored byte = alu_result OR (previous carry << 7), where the previous carry is initially 0; final carry = A bit 0.
REQ-026 In IDLE the ALU outputs SHALL be alu_a=0, alu_b=0, alu_op=0000, alu_carry_in=0.
REQ-027 start while busy=1 SHALL be ignored with no effect on the sequence or its latched operands.
REQ-028 start asserted in the done cycle SHALL be accepted, since the block is in IDLE; done still pulses exactly once for the prior operation.
REQ-029 result, carry and zero SHALL be valid from the done cycle and held until the next accepted start.
REQ-030 zero SHALL be computed over bytes 0..N-1 only.
REQ-031 Operand inputs changing during RUN SHALL have no effect.

Reset
REQ-032 rst_n=0 at any time, including mid-RUN, SHALL immediately force IDLE with busy=0, done=0, result=0, carry=0, zero=0, all ALU outputs 0, and the index and internal carry cleared.
REQ-033 After rst_n deasserts, the first start SHALL behave as in REQ-019, with no residual state from an aborted sequence.

Verification
REQ-034 ADD, nbytes=3, opa=0x00FF_FFFF, opb=0x0000_0001 -> done after 4 cycles, result=0x0100_0000, carry=0, zero=0; alu_op sequence ADD, ADC, ADC, ADC.
REQ-035 SUB, nbytes=1, opa=0x0000, opb=0x0001 -> result=0x0000_FFFF, carry=1, zero=0; alu_op sequence SUB, SBC.
REQ-036 SHR, nbytes=1, opa=0x0103 -> result=0x0000_0081, carry=1; ALU byte order 0x01 then 0x03.
REQ-037 SHL, nbytes=0, opa=0x80 -> result=0x00, carry=1, zero=1, done one cycle after start accepted.
REQ-038 Mid-sequence control: start pulsed during RUN -> ignored, single done; rst_n low at RUN cycle 2 -> all outputs 0 immediately; a new ADD 0x01+0x01 (nbytes=0) afterwards -> result=0x02.
REQ-039 Back-to-back: start held high across the done cycle -> the second operation begins there; busy and done timing per REQ-020 for both operations.
